// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage RAW interlock, wrong-path kill and issue strobe
module id_hazard_ctrl #(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_rf_we,
    input  logic [4:0]       id_dest,
    input  logic             id_br_taken,
    input  logic             pipe_adv,
    output logic             stall_id,
    output logic             issue,
    output logic             kill_id,
    output logic [DEPTH-1:0] sb_busy,
    output logic [31:0]      stall_cnt
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] we_q;
    logic [4:0]       dest_q [DEPTH];
    logic             kill_q;
    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;
    logic             kill_d;
    logic             hit;

    // The WB slot is skipped when the register file writes through to readers.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v_q[i] && we_q[i] && (dest_q[i] != 5'd0) &&
                ((id_rs1_used && (id_rs1 == dest_q[i])) ||
                 (id_rs2_used && (id_rs2 == dest_q[i]))) &&
                !(WB_BYPASS && (i == DEPTH - 1))) begin
                hit = 1'b1;
            end
        end
    end

    assign kill_id   = kill_q & id_valid;
    assign stall_id  = id_valid & ~kill_id & hit;
    assign issue     = id_valid & ~kill_id & ~stall_id & pipe_adv;
    assign sb_busy   = v_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        kill_d = kill_q;
        if (kill_id) begin
            kill_d = 1'b0;
        end
        if (issue && id_br_taken) begin
            kill_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= '0;
            we_q        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dest_q[k] <= 5'd0;
            end
            kill_q      <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            kill_q      <= kill_d;
            stall_cnt_q <= stall_cnt_d;
            if (pipe_adv) begin
                for (int k = 1; k < DEPTH; k++) begin
                    v_q[k]    <= v_q[k-1];
                    we_q[k]   <= we_q[k-1];
                    dest_q[k] <= dest_q[k-1];
                end
                v_q[0]    <= issue;
                we_q[0]   <= id_rf_we & issue;
                dest_q[0] <= id_dest;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed bench for id_hazard_ctrl, both WB_BYPASS settings
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_rs1_used = 1'b0;
    logic        id_rs2_used = 1'b0;
    logic        id_rf_we = 1'b0;
    logic [4:0]  id_dest = 5'd0;
    logic        id_br_taken = 1'b0;
    logic        pipe_adv = 1'b1;

    logic        stall0, issue0, kill0;
    logic [2:0]  busy0;
    logic [31:0] cnt0;
    logic        stall1, issue1, kill1;
    logic [2:0]  busy1;
    logic [31:0] cnt1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.DEPTH(3), .WB_BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rf_we(id_rf_we), .id_dest(id_dest), .id_br_taken(id_br_taken),
        .pipe_adv(pipe_adv), .stall_id(stall0), .issue(issue0),
        .kill_id(kill0), .sb_busy(busy0), .stall_cnt(cnt0)
    );

    id_hazard_ctrl #(.DEPTH(3), .WB_BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rf_we(id_rf_we), .id_dest(id_dest), .id_br_taken(id_br_taken),
        .pipe_adv(pipe_adv), .stall_id(stall1), .issue(issue1),
        .kill_id(kill1), .sb_busy(busy1), .stall_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic we, input logic [4:0] dst, input logic br);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rf_we = we; id_dest = dst; id_br_taken = br;
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick(); tick(); tick();
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall0}, 32'd0);
        chk("rst_issue", {31'd0, issue0}, 32'd0);
        chk("rst_kill", {31'd0, kill0}, 32'd0);
        chk("rst_busy", {29'd0, busy0}, 32'd0);
        chk("rst_cnt", cnt0, 32'd0);
        tick();
        chk("idle_busy", {29'd0, busy0}, 32'd0);

        // add.w r5 then add.w r6,r5,r7
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        chk("wr_issue", {31'd0, issue0}, 32'd1);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b1, 5'd6, 1'b0);
        chk("raw_ex_stall0", {31'd0, stall0}, 32'd1);
        chk("raw_ex_stall1", {31'd0, stall1}, 32'd1);
        chk("raw_ex_issue0", {31'd0, issue0}, 32'd0);
        chk("raw_ex_busy", {29'd0, busy0}, 32'd1);
        tick();
        chk("raw_mem_stall0", {31'd0, stall0}, 32'd1);
        chk("raw_mem_stall1", {31'd0, stall1}, 32'd1);
        chk("raw_mem_busy", {29'd0, busy0}, 32'd2);
        tick();
        chk("raw_wb_stall0", {31'd0, stall0}, 32'd1);
        chk("raw_wb_stall1", {31'd0, stall1}, 32'd0);
        chk("raw_wb_issue1", {31'd0, issue1}, 32'd1);
        chk("raw_wb_busy", {29'd0, busy0}, 32'd4);
        tick();
        chk("raw_done_stall0", {31'd0, stall0}, 32'd0);
        chk("raw_done_issue0", {31'd0, issue0}, 32'd1);
        chk("raw_cnt0", cnt0, 32'd3);
        chk("raw_cnt1", cnt1, 32'd2);
        tick();
        drain();
        chk("drain_busy", {29'd0, busy0}, 32'd0);

        // r0 writer followed by r0 reader
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        chk("r0_wr_issue", {31'd0, issue0}, 32'd1);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        chk("r0_rd_stall", {31'd0, stall0}, 32'd0);
        chk("r0_rd_issue", {31'd0, issue0}, 32'd1);
        tick();
        chk("r0_rd2_issue", {31'd0, issue0}, 32'd1);
        chk("r0_cnt0", cnt0, 32'd3);
        tick();
        drain();

        // taken branch kills the next instruction
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("br_issue", {31'd0, issue0}, 32'd1);
        chk("br_kill", {31'd0, kill0}, 32'd0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        chk("wp_kill", {31'd0, kill0}, 32'd1);
        chk("wp_issue", {31'd0, issue0}, 32'd0);
        chk("wp_busy", {29'd0, busy0}, 32'd1);
        tick();
        chk("tgt_busy0", {31'd0, busy0[0]}, 32'd0);
        chk("tgt_kill", {31'd0, kill0}, 32'd0);
        chk("tgt_issue", {31'd0, issue0}, 32'd1);
        tick();

        // kill flag holds across an empty ID slot
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("hold_kill_novalid", {31'd0, kill0}, 32'd0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("hold_kill", {31'd0, kill1}, 32'd1);
        chk("hold_issue", {31'd0, issue1}, 32'd0);
        tick();
        chk("hold_clear", {31'd0, kill1}, 32'd0);
        drain();

        // frozen back end: shadow holds, stall counted every cycle
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        tick();
        pipe_adv = 1'b0;
        drive(1'b1, 5'd1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd2, 1'b0);
        chk("frz_stall", {31'd0, stall0}, 32'd1);
        chk("frz_issue", {31'd0, issue0}, 32'd0);
        tick(); tick(); tick(); tick();
        chk("frz_busy0", {29'd0, busy0}, 32'd1);
        chk("frz_busy1", {29'd0, busy1}, 32'd1);
        chk("frz_cnt0", cnt0, 32'd7);
        chk("frz_cnt1", cnt1, 32'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {29'd0, busy0}, 32'd0);
        chk("arst_cnt0", cnt0, 32'd0);
        chk("arst_cnt1", cnt1, 32'd0);
        chk("arst_stall", {31'd0, stall0}, 32'd0);
        tick();
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Interlock controller in front of the ID→EX boundary of the 5-stage LoongArch pipeline.
- Keeps a shadow scoreboard of in-flight register writers (EX, MEM, WB).
- Stalls ID on read-after-write hazards, since the datapath has no forwarding.
- Kills the wrong-path instruction that follows a taken branch.
- Generates the issue strobe that advances ID into EX.

Parameters:
- DEPTH, 3, number of shadow stages behind ID (EX=0, MEM=1, WB=DEPTH-1); legal range 2..4.
- WB_BYPASS, 0, 1 = register file is write-through, so the WB entry is excluded from hazard matching; 0 = WB matches too.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  5  first source register (rj).
- id_rs2  in  5  second source register (rk or rd).
- id_rs1_used  in  1  rs1 is actually read.
- id_rs2_used  in  1  rs2 is actually read.
- id_rf_we  in  1  instruction writes the GPR file.
- id_dest  in  5  destination register.
- id_br_taken  in  1  ID resolves a taken branch or jump this cycle.
- pipe_adv  in  1  back end (EX..WB) advances this cycle.
- stall_id  out  1  RAW hazard; ID must hold.
- issue  out  1  ID instruction moves into EX this cycle.
- kill_id  out  1  current ID instruction is wrong-path and is dropped.
- sb_busy  out  DEPTH  per-stage shadow valid bits, bit0 = EX.
- stall_cnt  out  32  hazard-stall cycle counter, saturating.

Behaviour:
- Reset values: all shadow entries invalid, kill flag 0, stall_cnt 0. Outputs after reset: stall_id=0, issue=0, kill_id=0, sb_busy=0.
- Reset is asynchronous: asserting it mid-operation clears everything immediately, regardless of clk.
- Shadow entry contents: {v, we, dest}.
- A match occurs for entry i when all of the following hold:
  - v & we;
  - dest != 0;
  - (id_rs1_used & id_rs1==dest) | (id_rs2_used & id_rs2==dest);
  - entry i is not WB while WB_BYPASS=1.
- stall_id = id_valid & ~kill_id & (OR of matches). It is combinational from registers and ID inputs, zero added latency.
- kill_id = kill flag & id_valid.
- issue = id_valid & ~kill_id & ~stall_id & pipe_adv.
- Shadow pipeline on the clock edge, only when pipe_adv=1:
  - entry[k] <= entry[k-1] for k ≥ 1;
  - entry[0] <= {issue, id_rf_we & issue, id_dest}. A bubble is inserted when there is no issue.
  - When pipe_adv=0 all entries hold and issue=0.
- Kill flag:
  - set on any edge where issue & id_br_taken;
  - cleared on an edge where kill_id=1, i.e. the wrong-path instruction is consumed;
  - set has priority over clear, which cannot coincide because issue and kill_id are exclusive.
  - While the flag is set and id_valid=0, the flag holds.
- id_br_taken is ignored unless issue=1, so a stalled branch never sets the kill flag.
- stall_cnt increments by 1 each cycle with stall_id=1 and saturates at 32'hFFFFFFFF.
- Writes to r0 never create hazards.
- Same dest in multiple entries: any match stalls.
- Longest stall: a hazard against EX with WB_BYPASS=0 and pipe_adv=1 every cycle stalls 3 cycles; with WB_BYPASS=1 it stalls 2 cycles.

Test Plan:
- Reset then idle, id_valid=0 → stall_id=0, issue=0, sb_busy=3'b000, stall_cnt=0.
- Issue add.w r5 (id_rf_we=1, dest=5); next cycle add.w r6,r5,r7 (rs1=5 used), pipe_adv=1, WB_BYPASS=0 → stall_id=1 for 3 cycles, issue on the 4th cycle, stall_cnt=3.
- Same sequence with WB_BYPASS=1 → stall for 2 cycles, stall_cnt=2.
- Writer dest=0, then reader rs1=0 → no stall, issue every cycle.
- Issue beq with id_br_taken=1; next cycle id_valid=1 → kill_id=1, issue=0, sb_busy bit0=0 after the edge. The following cycle kill_id=0 and the target instruction issues.
- Hazard pending, pipe_adv=0 for 4 cycles → shadow frozen, stall_cnt +4; then assert reset asynchronously mid-cycle → sb_busy=0, stall_cnt=0 before the next clk edge.
